// File: rtl/led_cube_pkg.sv
// LED cube frame streamer shared types and constants.
// Frame geometry, stream frame count and read-FSM state encoding.
package led_cube_pkg;

  localparam int FRAME_BYTES   = 64;
  localparam int STREAM_FRAMES = 8;
  localparam int ROW_W         = $clog2(FRAME_BYTES);
  localparam int IDX_W         = $clog2(STREAM_FRAMES);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_BURST,
    ST_GAP
  } rd_state_e;

  // Writes alternate banks, so when both are full the write bank
  // holds the older frame; otherwise the single full bank is picked.
  function automatic logic pick_bank(
    input logic [1:0] full,
    input logic       wbank
  );
    return (&full) ? wbank : full[1];
  endfunction

endpackage

// File: rtl/led_frame_bank.sv
// One 64x8 frame buffer bank.
// Synchronous write port, registered read port.
module led_frame_bank
  import led_cube_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [ROW_W-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic             i_re,
  input  logic [ROW_W-1:0] i_raddr,
  output logic [7:0]       o_rdata
);

  logic [7:0] r_mem [FRAME_BYTES];
  logic [7:0] r_rdata;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/led_frame_streamer.sv
// Ping-pong buffered host-frame to LED cube streamer.
// Host fills 64-byte banks; read FSM bursts each full bank out.
module led_frame_streamer
  import led_cube_pkg::*;
#(
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             frame_sync,
  output logic             stream_read,
  output logic [7:0]       data_out,
  output logic [IDX_W-1:0] frame_idx,
  output logic             frame_sent
);

  localparam logic [7:0] GAP_LAST = 8'(FRAME_GAP - 1);

  rd_state_e        r_state;
  rd_state_e        w_next;
  logic [1:0]       r_full;
  logic [1:0]       w_full_nx;
  logic             r_wbank;
  logic [ROW_W-1:0] r_wrow;
  logic             r_rbank;
  logic [ROW_W-1:0] r_rrow;
  logic [7:0]       r_gap;
  logic             r_sent;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_last;

  logic             w_ready;
  logic             w_accept;
  logic [ROW_W-1:0] w_wrow;
  logic             w_wdone;
  logic             w_release;
  logic             w_gap_end;
  logic             w_pick;
  logic             w_start;
  logic             w_re;
  logic [ROW_W-1:0] w_raddr;
  logic             w_rsel;
  logic [7:0]       w_rdata0;
  logic [7:0]       w_rdata1;
  logic [7:0]       w_rdata;

  assign w_ready   = ~r_full[r_wbank];
  assign w_accept  = byte_valid & w_ready;
  assign w_wrow    = frame_sync ? '0 : r_wrow;
  assign w_wdone   = w_accept && (w_wrow == LAST_ROW);
  assign w_release = (r_state == ST_BURST) && (r_rrow == LAST_ROW);
  assign w_gap_end = (r_state == ST_GAP) && (r_gap == GAP_LAST);
  assign w_pick    = pick_bank(r_full, r_wbank);

  // The last gap cycle doubles as the prime cycle so back-to-back
  // bursts are separated by exactly FRAME_GAP low cycles.
  assign w_start = enable && (|r_full) &&
                   ((r_state == ST_IDLE) || w_gap_end);

  assign w_rsel  = w_gap_end ? w_pick : r_rbank;
  assign w_rdata = r_rbank ? w_rdata1 : w_rdata0;

  led_frame_bank u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept && !r_wbank),
    .i_waddr (w_wrow),
    .i_wdata (byte_in),
    .i_re    (w_re && !w_rsel),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata0)
  );

  led_frame_bank u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept && r_wbank),
    .i_waddr (w_wrow),
    .i_wdata (byte_in),
    .i_re    (w_re && w_rsel),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata1)
  );

  // Read FSM next state and bank read-port control.
  always_comb begin
    w_next  = r_state;
    w_re    = 1'b0;
    w_raddr = r_rrow + 6'd1;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_PRIME;
      end
      ST_PRIME: begin
        w_next  = ST_BURST;
        w_re    = 1'b1;
        w_raddr = '0;
      end
      ST_BURST: begin
        w_re = (r_rrow != LAST_ROW);
        if (r_rrow == LAST_ROW) w_next = ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_end) begin
          if (w_start) begin
            w_next  = ST_BURST;
            w_re    = 1'b1;
            w_raddr = '0;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Full flags: release and completion may land in the same cycle.
  always_comb begin
    w_full_nx = r_full;
    if (w_release) w_full_nx[r_rbank] = 1'b0;
    if (w_wdone)   w_full_nx[r_wbank] = 1'b1;
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Burst row and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrow <= '0;
      r_gap  <= '0;
    end else begin
      r_rrow <= (r_state == ST_BURST) ? r_rrow + 6'd1 : '0;
      r_gap  <= (r_state == ST_GAP) ? r_gap + 8'd1 : '0;
    end
  end

  // Read bank selection, captured when a burst is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rbank <= 1'b0;
    else if (w_start) r_rbank <= w_pick;
  end

  // Write pointer and bank occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= '0;
      r_wbank <= 1'b0;
      r_wrow  <= '0;
    end else begin
      r_full <= w_full_nx;
      if (w_wdone) begin
        r_wbank <= ~r_wbank;
        r_wrow  <= '0;
      end else if (w_accept) begin
        r_wrow <= w_wrow + 6'd1;
      end else if (frame_sync) begin
        r_wrow <= '0;
      end
    end
  end

  // Completion pulse and frame index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sent <= 1'b0;
      r_idx  <= '0;
    end else begin
      r_sent <= w_release;
      if (w_release) r_idx <= r_idx + 3'd1;
    end
  end

  // Hold the last streamed byte while the stream is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_last <= '0;
    else if (stream_read) r_last <= w_rdata;
  end

  assign byte_ready  = w_ready;
  assign stream_read = (r_state == ST_BURST);
  assign data_out    = stream_read ? w_rdata : r_last;
  assign frame_idx   = r_idx;
  assign frame_sent  = r_sent;

endmodule

// File: tb/tb_led_frame_streamer.sv
// Directed self-checking bench for led_frame_streamer.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_led_frame_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       byte_ready;
  logic       stream_read;
  logic [7:0] data_out;
  logic [2:0] frame_idx;
  logic       frame_sent;

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  led_frame_streamer #(.FRAME_GAP(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .frame_sync  (frame_sync),
    .stream_read (stream_read),
    .data_out    (data_out),
    .frame_idx   (frame_idx),
    .frame_sent  (frame_sent)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b, input logic sync);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    frame_sync = sync;
    while (!byte_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready", byte_ready, 1'b1);
    @(negedge clk);
    byte_valid = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] base);
    for (int k = 0; k < 64; k++) wr(8'(base + k), 1'b0);
  endtask

  task automatic wait_sr();
    int n;
    n = 0;
    while (!stream_read && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("burst_start", stream_read, 1'b1);
  endtask

  task automatic check_burst(input logic [7:0] f,
                             input logic [7:0] base,
                             input int k0,
                             input int k1);
    logic [7:0] e;
    for (int k = k0; k < k1; k++) begin
      e = (k == 0) ? f : 8'(base + k);
      chk($sformatf("burst_sr[%0d]", k), stream_read, 1'b1);
      chk($sformatf("burst_data[%0d]", k), data_out, e);
      @(negedge clk);
    end
  endtask

  task automatic post_burst(input logic [2:0] idx,
                            input logic [7:0] last);
    chk("frame_sent", frame_sent, 1'b1);
    chk("gap_sr", stream_read, 1'b0);
    chk("frame_idx", frame_idx, idx);
    chk("hold_data", data_out, last);
  endtask

  initial begin
    int low;
    int hits;

    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sr", stream_read, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_idx", frame_idx, 3'd0);
    chk("rst_sent", frame_sent, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", byte_ready, 1'b1);

    // Single frame 0x00..0x3F
    wr_frame(8'h00);
    wait_sr();
    check_burst(8'h00, 8'h00, 0, 64);
    post_burst(3'd1, 8'h3F);
    @(negedge clk);
    chk("sent_pulse_end", frame_sent, 1'b0);
    chk("hold_data2", data_out, 8'h3F);
    repeat (4) @(negedge clk);

    // Two queued frames, back-pressure, gap length
    enable = 1'b0;
    wr_frame(8'h80);
    wr_frame(8'hC0);
    byte_in    = 8'h5A;
    byte_valid = 1'b1;
    @(negedge clk);
    chk("full_ready", byte_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("full_ready2", byte_ready, 1'b0);
    chk("no_burst_disabled", stream_read, 1'b0);
    enable = 1'b1;
    wait_sr();
    check_burst(8'h80, 8'h80, 0, 64);
    post_burst(3'd2, 8'hBF);
    chk("held_accept", byte_ready, 1'b1);
    @(negedge clk);
    byte_valid = 1'b0;
    low = 1;
    while (!stream_read && low < 50) begin
      low++;
      @(negedge clk);
    end
    chk("gap_low_cycles", low, 2);
    check_burst(8'hC0, 8'hC0, 0, 64);
    post_burst(3'd3, 8'hFF);
    repeat (4) @(negedge clk);

    // frame_sync discards a partial frame
    for (int k = 0; k < 30; k++) wr(8'(8'h10 + k), 1'b0);
    wr(8'hAA, 1'b1);
    for (int k = 0; k < 63; k++) wr(8'(8'h20 + k), 1'b0);
    wait_sr();
    check_burst(8'hAA, 8'h1F, 0, 64);
    post_burst(3'd4, 8'h5E);
    repeat (4) @(negedge clk);

    // Reset in the middle of a burst
    wr_frame(8'h60);
    wait_sr();
    check_burst(8'h60, 8'h60, 0, 20);
    rst_n = 1'b0;
    #1;
    chk("midrst_sr", stream_read, 1'b0);
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_idx", frame_idx, 3'd0);
    chk("midrst_sent", frame_sent, 1'b0);
    chk("midrst_ready", byte_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (150) begin
      @(negedge clk);
      if (stream_read) hits++;
    end
    chk("no_resume", hits, 0);

    // Nine frames: index wraps 7 -> 0
    for (int f = 0; f < 9; f++) begin
      wr_frame(8'(f * 16));
      wait_sr();
      check_burst(8'(f * 16), 8'(f * 16), 0, 64);
      post_burst(3'(f + 1), 8'(f * 16 + 63));
    end
    repeat (4) @(negedge clk);

    // enable dropped mid-burst
    wr_frame(8'h33);
    wait_sr();
    check_burst(8'h33, 8'h33, 0, 10);
    enable = 1'b0;
    check_burst(8'h33, 8'h33, 10, 64);
    post_burst(3'd2, 8'h72);
    wr_frame(8'h44);
    hits = 0;
    repeat (150) begin
      @(negedge clk);
      if (stream_read) hits++;
    end
    chk("no_burst_after_disable", hits, 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
